// File: rtl/prog_rom_arbiter.sv
// prog_rom_arbiter: two-port (IF/DBG) arbiter in front of a 1-cycle-latency program ROM.
module prog_rom_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic        if_gnt_o,
  output logic        if_valid_o,
  output logic [31:0] if_data_o,
  input  logic        dbg_req_i,
  input  logic [31:0] dbg_addr_i,
  output logic        dbg_gnt_o,
  output logic        dbg_valid_o,
  output logic [31:0] dbg_data_o,
  output logic        dbg_err_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i
);
  localparam int CW = STARVE_LIMIT > 0 ? $clog2(STARVE_LIMIT + 1) : 1;
  typedef enum logic [1:0] {NONE, IF_PEND, DBG_PEND, DBG_ERR_PEND} tag_e;
  tag_e tag_q, tag_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [31:0] rom_addr_q, if_hold_q, dbg_hold_q;
  logic force_dbg, dbg_ill;
  always_comb begin
    force_dbg = dbg_req_i && starve_q == CW'(STARVE_LIMIT);
    dbg_gnt_o = !rst_i && dbg_req_i && (!if_req_i || force_dbg);
    if_gnt_o = !rst_i && if_req_i && !dbg_gnt_o;
    dbg_ill = |dbg_addr_i[1:0] || |dbg_addr_i[31:16];
    starve_d = (!dbg_req_i || dbg_gnt_o) ? '0 :
               starve_q == CW'(STARVE_LIMIT) ? starve_q : starve_q + 1'b1;
    tag_d = if_gnt_o ? IF_PEND : dbg_gnt_o ? (dbg_ill ? DBG_ERR_PEND : DBG_PEND) : NONE;
    rom_addr_o = if_gnt_o ? if_addr_i : dbg_gnt_o ? dbg_addr_i : rom_addr_q;
    // A flush in the response cycle kills the IF response and keeps the old hold value
    if_valid_o = tag_q == IF_PEND && !if_flush_i;
    if_data_o = if_valid_o ? rom_data_i : if_hold_q;
    dbg_valid_o = tag_q == DBG_PEND || tag_q == DBG_ERR_PEND;
    dbg_err_o = tag_q == DBG_ERR_PEND;
    dbg_data_o = tag_q == DBG_PEND ? rom_data_i : tag_q == DBG_ERR_PEND ? '0 : dbg_hold_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_q <= NONE;
      starve_q <= '0;
      rom_addr_q <= '0;
      if_hold_q <= '0;
      dbg_hold_q <= '0;
    end else begin
      tag_q <= tag_d;
      starve_q <= starve_d;
      rom_addr_q <= rom_addr_o;
      if_hold_q <= if_data_o;
      dbg_hold_q <= dbg_data_o;
    end
  end
endmodule

// File: tb/tb_prog_rom_arbiter.sv
// tb_prog_rom_arbiter: directed + random checks of prog_rom_arbiter against a transaction-level model.
module tb_prog_rom_arbiter;
  localparam int L = 4;
  logic clk = 0, rst;
  logic if_req, if_flush, dbg_req;
  logic [31:0] if_addr, dbg_addr;
  logic if_gnt, if_valid, dbg_gnt, dbg_valid, dbg_err;
  logic [31:0] if_data, dbg_data, rom_addr, rom_data = '0;
  int passes = 0, checks = 0, fails = 0;
  int starve = 0, pend = 0;
  logic [31:0] last_addr = '0, if_hold = '0, dbg_hold = '0;
  logic eg_if, eg_dbg;
  logic ri, rd;
  logic [31:0] ra, rda;

  prog_rom_arbiter #(.STARVE_LIMIT(L)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_gnt_o(if_gnt), .if_valid_o(if_valid), .if_data_o(if_data),
    .dbg_req_i(dbg_req), .dbg_addr_i(dbg_addr),
    .dbg_gnt_o(dbg_gnt), .dbg_valid_o(dbg_valid), .dbg_data_o(dbg_data), .dbg_err_o(dbg_err),
    .rom_addr_o(rom_addr), .rom_data_i(rom_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] romw(input logic [13:0] w);
    return {w ^ 14'h2a5b, 4'h9, w};
  endfunction

  always @(posedge clk) rom_data <= romw(rom_addr[15:2]);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic ifr, input logic [31:0] ifa, input logic fl,
                      input logic dbr, input logic [31:0] dba);
    logic ev;
    logic [31:0] ed, dd, ea;
    if_req = ifr; if_addr = ifa; if_flush = fl; dbg_req = dbr; dbg_addr = dba;
    #1;
    eg_dbg = dbr && (!ifr || starve >= L);
    eg_if = ifr && !eg_dbg;
    ea = eg_if ? ifa : eg_dbg ? dba : last_addr;
    ev = pend == 1 && !fl;
    ed = ev ? romw(last_addr[15:2]) : if_hold;
    dd = pend == 2 ? romw(last_addr[15:2]) : pend == 3 ? 32'h0 : dbg_hold;
    chk("if_gnt", if_gnt, eg_if);
    chk("dbg_gnt", dbg_gnt, eg_dbg);
    chk("rom_addr", rom_addr, ea);
    chk("if_valid", if_valid, ev);
    chk("if_data", if_data, ed);
    chk("dbg_valid", dbg_valid, pend >= 2);
    chk("dbg_err", dbg_err, pend == 3);
    chk("dbg_data", dbg_data, dd);
    @(posedge clk); #1;
    if_hold = ed;
    dbg_hold = dd;
    starve = (dbr && !eg_dbg) ? (starve < L ? starve + 1 : L) : 0;
    pend = eg_if ? 1 : eg_dbg ? ((dba[1:0] != 0 || dba[31:16] != 0) ? 3 : 2) : 0;
    last_addr = ea;
  endtask

  task automatic idle();
    step(0, 32'h0, 0, 0, 32'h0);
  endtask

  initial begin
    rst = 1; if_req = 0; if_addr = 0; if_flush = 0; dbg_req = 0; dbg_addr = 0;
    #2;
    if_req = 1; dbg_req = 1; if_addr = 32'h44; dbg_addr = 32'h8;
    #1;
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_dbg_gnt", dbg_gnt, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_dbg_valid", dbg_valid, 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_dbg_data", dbg_data, 0);
    chk("rst_dbg_err", dbg_err, 0);
    if_req = 0; dbg_req = 0;
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    // single IF fetch of word 4
    step(1, 32'h10, 0, 0, 32'h0);
    idle();
    chk("word4_data", if_data, romw(14'd4));
    // both held: IF wins until the starve limit forces DBG through
    for (int i = 0; i < 12; i++) step(1, 32'h100 + 32'(4 * i), 0, 1, 32'h200);
    idle();
    // illegal debug addresses
    step(0, 32'h0, 0, 1, 32'h0000_0002);
    step(0, 32'h0, 0, 1, 32'h0001_0000);
    idle();
    step(0, 32'h0, 0, 1, 32'h0000_fffc);
    idle();
    // flush kills the 0x20 response; the 0x40 grant in the flush cycle survives
    step(1, 32'h20, 0, 0, 32'h0);
    step(1, 32'h40, 1, 0, 32'h0);
    idle();
    chk("flush_word10", if_data, romw(14'h10));
    step(0, 32'h0, 1, 0, 32'h0);
    // alternating single-cycle requests
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) step(1, 32'h300 + 32'(4 * i), 0, 0, 32'h0);
      else step(0, 32'h0, 0, 1, 32'h400 + 32'(4 * i));
    end
    idle();
    // async reset with a DBG response in flight
    step(0, 32'h0, 0, 1, 32'h80);
    #1 rst = 1;
    dbg_req = 1; if_req = 1;
    #1;
    chk("arst_dbg_valid", dbg_valid, 0);
    chk("arst_dbg_data", dbg_data, 0);
    chk("arst_if_data", if_data, 0);
    chk("arst_rom_addr", rom_addr, 0);
    chk("arst_dbg_gnt", dbg_gnt, 0);
    chk("arst_if_gnt", if_gnt, 0);
    dbg_req = 0; if_req = 0;
    #2 rst = 0;
    @(posedge clk); #1;
    starve = 0; pend = 0; last_addr = 0; if_hold = 0; dbg_hold = 0;
    idle();
    // random traffic; requesters keep req/addr stable until granted
    ri = 0; rd = 0; ra = 0; rda = 0;
    for (int i = 0; i < 400; i++) begin
      step(ri, ra, ($urandom % 4) == 0, rd, rda);
      if (eg_if || !ri) begin
        ri = ($urandom % 3) != 0;
        ra = $urandom;
      end
      if (eg_dbg || !rd) begin
        rd = ($urandom % 2) != 0;
        rda = ($urandom % 4 == 0) ? $urandom : {16'h0, 16'($urandom) & 16'hfffc};
      end
    end
    idle();
    idle();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/prog_rom_arbiter.md
PROG_ROM_ARBITER -- requirements
Module: prog_rom_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, max consecutive cycles a pending DBG request may lose to IF before being forced through.
REQ-002 CLK  in  1  system clock; all state updates on rising edge.
REQ-003 RST  in  1  reset, asynchronous, active-high.
REQ-004 IF_REQ  in  1  instruction-fetch read request.
REQ-005 IF_ADDR  in  32  fetch byte address.
REQ-006 IF_FLUSH  in  1  cancel the in-flight IF response (branch/redirect).
REQ-007 IF_GNT  out  1  IF request accepted this cycle (combinational).
REQ-008 IF_VALID  out  1  IF_DATA valid this cycle.
REQ-009 IF_DATA  out  32  fetched instruction.
REQ-010 DBG_REQ  in  1  debug/loader read request.
REQ-011 DBG_ADDR  in  32  debug byte address.
REQ-012 DBG_GNT  out  1  DBG request accepted this cycle (combinational).
REQ-013 DBG_VALID  out  1  DBG_DATA/DBG_ERR valid this cycle.
REQ-014 DBG_DATA  out  32  debug read data.
REQ-015 DBG_ERR  out  1  debug address illegal.
REQ-016 ROM_ADDR  out  32  byte address to program ROM.
REQ-017 ROM_DATA  in  32  ROM read data, valid one cycle after ROM_ADDR is sampled.

Function
REQ-018 At most one of IF_GNT/DBG_GNT shall be high per cycle; one grant per cycle, back-to-back grants allowed.
REQ-019 Default priority: IF wins when both request.
REQ-020 Starve counter: increments each cycle DBG_REQ=1 and DBG_GNT=0; clears on DBG_GNT or DBG_REQ=0; saturates at STARVE_LIMIT.
REQ-021 When counter==STARVE_LIMIT and DBG_REQ=1, DBG shall be granted regardless of IF_REQ.
REQ-022 ROM_ADDR = granted requester's address in the grant cycle; otherwise holds last granted address (register).
REQ-023 In-flight tag FSM, states NONE, IF_PEND, DBG_PEND, DBG_ERR_PEND; next state from this cycle's grant (IF_GNT->IF_PEND, legal DBG_GNT->DBG_PEND, illegal DBG_GNT->DBG_ERR_PEND, no grant->NONE).
REQ-024 Latency: grant in cycle N -> VALID high exactly in cycle N+1, single cycle.
REQ-025 IF_PEND: IF_VALID=1, IF_DATA=ROM_DATA; DBG_PEND: DBG_VALID=1, DBG_DATA=ROM_DATA, DBG_ERR=0.
REQ-026 DBG address illegal when DBG_ADDR[1:0]!=0 or DBG_ADDR[31:16]!=0; DBG_ERR_PEND: DBG_VALID=1, DBG_ERR=1, DBG_DATA=0.
REQ-027 IF_DATA and DBG_DATA shall hold their last valid value in non-valid cycles (hold registers).
REQ-028 IF_FLUSH in cycle N+1 suppresses IF_VALID for a grant made in cycle N, and the IF_DATA hold register is not updated; a grant in the flush cycle itself is unaffected.
REQ-029 IF_FLUSH with no IF response in flight shall have no effect.
REQ-030 Requesters hold REQ and ADDR stable until GNT; arbiter does not latch un-granted requests.
REQ-031 IF addresses are not range-checked; bits [15:2] select the word.

Reset
REQ-032 RST=1 immediately forces: tag NONE, starve counter 0, ROM_ADDR hold 0, IF_DATA/DBG_DATA 0, IF_VALID/DBG_VALID/DBG_ERR 0.
REQ-033 While RST=1, IF_GNT and DBG_GNT shall be 0.
REQ-034 RST asserted with a response in flight: response discarded, no VALID after release.
REQ-035 First grant possible in the first cycle with RST=0.

Verification
REQ-036 IF_REQ=1 IF_ADDR=0x10 only -> IF_GNT same cycle, ROM_ADDR=0x10, next cycle IF_VALID=1 IF_DATA=ROM_DATA(word 4).
REQ-037 IF_REQ and DBG_REQ held high continuously, STARVE_LIMIT=4 -> IF granted 4 cycles, DBG granted cycle 5, counter back to 0; pattern repeats.
REQ-038 DBG_ADDR=0x0000_0002 and then 0x0001_0000 -> DBG_GNT, next cycle DBG_VALID=1 DBG_ERR=1 DBG_DATA=0, IF outputs unchanged.
REQ-039 IF grant at cycle N (addr 0x20), IF_FLUSH at N+1 with new IF grant (addr 0x40) -> no IF_VALID at N+1, IF_VALID at N+2 with word 0x10 data.
REQ-040 RST pulsed mid-cycle after a DBG grant -> all outputs 0 asynchronously, no DBG_VALID after release.
REQ-041 Alternating IF/DBG single-cycle requests -> every grant yields exactly one VALID on the correct port, IF_GNT&DBG_GNT never both 1.
